// File: rtl/adc_display_scan_if.sv
// rtl/adc_display_scan_if.sv - sample input / display output bundle for adc_display_scan
//
// Ports (signals):
//   data_i      unsigned ADC sample, DATA_W bits
//   data_valid  one-cycle sample strobe
//   hex_mode    1 = raw hex display, 0 = decimal; sampled with data_valid
//   busy        decimal conversion in progress; strobes are dropped while high
//   overflow    latched result does not fit in NUM_DIGITS
//   sel         one-hot digit enable, bit 0 = least-significant digit
//   segments    active-low segments {g,f,e,d,c,b,a}
// Modports: master (sample source / pin observer), slave (adc_display_scan).
interface adc_display_scan_if #(
    parameter int DATA_W     = 8,
    parameter int NUM_DIGITS = 3
);
    logic [DATA_W-1:0]     data_i;
    logic                  data_valid;
    logic                  hex_mode;
    logic                  busy;
    logic                  overflow;
    logic [NUM_DIGITS-1:0] sel;
    logic [6:0]            segments;

    modport master (
        output data_i, data_valid, hex_mode,
        input  busy, overflow, sel, segments
    );

    modport slave (
        input  data_i, data_valid, hex_mode,
        output busy, overflow, sel, segments
    );
endinterface

// File: rtl/adc_display_scan.sv
// rtl/adc_display_scan.sv - ADC sample to multiplexed seven-segment display path
//
// Converts an accepted sample to BCD with a sequential double-dabble (one shift
// per clock, DATA_W clocks) or loads it as raw hex nibbles, holds the result in
// a display buffer and scans NUM_DIGITS digits from an internal prescaler.
// Ports:
//   clk_i    system clock
//   reset_n  asynchronous active-low reset
//   bus      adc_display_scan_if.slave (data_i, data_valid, hex_mode, busy,
//            overflow, sel, segments)
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zeros in decimal).
module adc_display_scan #(
    parameter int DATA_W     = 8,
    parameter int NUM_DIGITS = 3,
    parameter int PRESCALE   = 2080
) (
    input  logic              clk_i,
    input  logic              reset_n,
    adc_display_scan_if.slave bus
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int SR_W  = DATA_W + BCD_W;
    localparam int PS_W  = $clog2(PRESCALE);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [31:0] DEC_MAX = 32'(10 ** NUM_DIGITS - 1);

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t               state_q, state_d;
    logic [PS_W-1:0]      ps_cnt;
    logic                 tick;
    logic [IDX_W-1:0]     scan_idx;
    logic [SR_W-1:0]      sr_q, sr_adj, sr_shift;
    logic [CNT_W-1:0]     shift_cnt;
    logic                 dec_ovf_q;
    logic [BCD_W-1:0]     disp_buf, disp_buf_d;
    logic                 ovf_q, ovf_d;
    logic                 dec_mode_q, dec_mode_d;
    logic                 accept, load_dec, load_hex;
    logic [BCD_W+DATA_W-1:0] hex_ext;
    logic [3:0]           nib;
    logic                 blank;
    logic [6:0]           seg_d;
    logic [NUM_DIGITS-1:0] sel_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    assign tick     = (ps_cnt == PS_W'(PRESCALE - 1));
    assign hex_ext  = {{BCD_W{1'b0}}, bus.data_i};
    assign bus.busy = (state_q == S_CONV);
    assign bus.overflow = ovf_q;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) ps_cnt <= '0;
        else          ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
    end

    // Double-dabble step: correct every BCD nibble, then shift the whole register.
    always_comb begin
        sr_adj = sr_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sr_q[DATA_W+4*k +: 4] >= 4'd5)
                sr_adj[DATA_W+4*k +: 4] = sr_q[DATA_W+4*k +: 4] + 4'd3;
        end
        sr_shift = {sr_adj[SR_W-2:0], 1'b0};
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        load_dec = 1'b0;
        load_hex = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.data_valid) begin
                    accept = 1'b1;
                    if (bus.hex_mode) load_hex = 1'b1;
                    else              state_d  = S_CONV;
                end
            end
            S_CONV: begin
                if (shift_cnt == CNT_W'(DATA_W - 1)) begin
                    load_dec = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            sr_q      <= '0;
            shift_cnt <= '0;
            dec_ovf_q <= 1'b0;
        end else if (accept && !bus.hex_mode) begin
            sr_q      <= SR_W'(bus.data_i);
            shift_cnt <= '0;
            dec_ovf_q <= (32'(bus.data_i) > DEC_MAX);
        end else if (state_q == S_CONV) begin
            sr_q      <= sr_shift;
            shift_cnt <= shift_cnt + CNT_W'(1);
        end
    end

    // Next buffer contents; the scan samples this so a tick on the load edge
    // already shows the new value and the buffer never appears half-written.
    always_comb begin
        disp_buf_d = disp_buf;
        ovf_d      = ovf_q;
        dec_mode_d = dec_mode_q;
        if (load_hex) begin
            disp_buf_d = hex_ext[BCD_W-1:0];
            ovf_d      = |hex_ext[BCD_W +: DATA_W];
            dec_mode_d = 1'b0;
        end else if (load_dec) begin
            disp_buf_d = sr_shift[SR_W-1 -: BCD_W];
            ovf_d      = dec_ovf_q;
            dec_mode_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            disp_buf   <= '0;
            ovf_q      <= 1'b0;
            dec_mode_q <= 1'b1;
        end else begin
            disp_buf   <= disp_buf_d;
            ovf_q      <= ovf_d;
            dec_mode_q <= dec_mode_d;
        end
    end

    // scan_idx names the digit shown on the next tick, so the first tick after
    // reset lights digit 0.
    always_comb begin
        nib   = 4'h0;
        blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scan_idx == IDX_W'(k)) begin
                nib = disp_buf_d[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                blank = dec_mode_d && !ovf_d && (k != 0) &&
                        ((disp_buf_d >> (4 * k)) == '0);
`endif
            end
        end
        if (ovf_d && dec_mode_d) seg_d = 7'h3F;
        else if (blank)          seg_d = 7'h7F;
        else                     seg_d = seg_decode(nib);
        sel_d = NUM_DIGITS'(1) << scan_idx;
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            scan_idx     <= '0;
            bus.sel      <= '0;
            bus.segments <= 7'h7F;
        end else if (tick) begin
            scan_idx     <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
            bus.sel      <= sel_d;
            bus.segments <= seg_d;
        end
    end
endmodule
